serial_adder_ctrl: RTL and testbench
====================================

Name: serial_adder_ctrl

Overview:
Bit-serial multi-bit adder sequencer built around a single one-bit full-adder slice (sum = a^b^c, carry = majority(a,b,c)).
- Accepts a WIDTH-bit operand pair on a start strobe.
- Feeds the slice one bit per clock, LSB first, with a registered carry.
- Returns the WIDTH-bit result and carry-out with a done pulse.
- Used wherever area matters more than latency; replaces a WIDTH-wide ripple adder.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 2..64.

Ports:
clk  input  1  single clock, rising-edge.
rst  input  1  asynchronous, active-high reset.
start  input  1  request strobe; sampled only in IDLE.
a  input  WIDTH  operand A; captured on an accepted start.
b  input  WIDTH  operand B; captured on an accepted start.
busy  output  1  high while in RUN.
done  output  1  one-cycle pulse in DONE; result valid.
sum  output  WIDTH  registered result; holds the last completed value.
cout  output  1  registered carry-out of the MSB slice; holds the last completed value.

Behaviour:
- Reset (asynchronous, rst=1):
  - state=IDLE, busy=0, done=0, sum=0, cout=0.
  - Internal shift registers, carry flop and bit counter all cleared.
  - Reset mid-RUN aborts the operation; no done is produced and sum/cout read 0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 at edge k: load shA<=a, shB<=b, carry<=0 (carry<=cin_init, see Optional Feature), cnt<=0, go to RUN.
  - start=0: stay in IDLE.
- RUN (busy=1):
  - Each edge: r = shA[0]^shB[0]^carry; carry <= majority(shA[0], shB[0], carry).
  - shA and shB shift right by one; the result shift register shifts right with r entering at the MSB; cnt increments.
  - On the edge where cnt==WIDTH-1 (the WIDTH-th RUN edge), the last bit is processed and:
    - sum <= final result register contents, including that bit;
    - cout <= carry produced by that bit;
    - state goes to DONE.
- DONE:
  - done=1 and busy=0 for exactly one cycle; the next edge returns to IDLE.
- Latency: start accepted at edge k → busy=1 during cycles k+1..k+WIDTH → done=1 during the cycle following edge k+WIDTH.
  - Minimum start-to-start spacing is WIDTH+2 cycles.
- Start handling:
  - start is ignored in RUN and DONE; there is no queuing.
  - start must be re-asserted in IDLE to be accepted.
- Operand stability: a and b are sampled only at the accepting edge; later changes have no effect.
- sum/cout hold stable from the DONE transition until the next completion or reset; they are not disturbed during a subsequent RUN.
- Counter width is $clog2(WIDTH). The WIDTH=2^n wrap is never reached because the exit is cnt==WIDTH-1.
- Result is modulo 2^WIDTH. Overflow is visible only through cout (unsigned).

Optional Feature:
Macro SERIAL_ADDER_SUB_EN.
- Defined:
  - Adds port sub (input, 1), sampled with start.
  - When sub=1: B is captured as ~b, and the carry flop initialises to 1, giving a−b in two's complement.
  - cout=1 means no borrow (a≥b unsigned); cout=0 means borrow.
  - sub=0 behaves identically to the undefined build.
- Undefined:
  - No sub port; B is captured as b and carry initialises to 0.
  - Add only.

Test Plan:
- WIDTH=8, a=0x5A, b=0x3C, start 1 cycle → busy high 8 cycles, done pulse 1 cycle, sum=0x96, cout=0.
- a=0xFF, b=0x01 → sum=0x00, cout=1; a=0xFF, b=0xFF → sum=0xFE, cout=1.
- Result holding and ignored start: start at k with a=0x01, b=0x02; pulse start again at k+3 with a=0x7F, b=0x7F → only one done, sum=0x03. During a following run, sum stays 0x03 until the new done.
- Reset abort: assert rst at cycle k+4 of a run on a=0xAA, b=0x55 → busy/done/sum/cout=0 immediately. A following start with a=0x10, b=0x20 yields sum=0x30 after 8 cycles.
- Back-to-back: start held high continuously with a=0x11, b=0x22 → done pulses every WIDTH+2=10 cycles, sum=0x33 each time.
- SERIAL_ADDER_SUB_EN defined, sub=1:
  - a=0x10, b=0x01 → sum=0x0F, cout=1.
  - a=0x00, b=0x01 → sum=0xFF, cout=0.
  - sub=0: a=0x10, b=0x01 → sum=0x11.

Source files
------------

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial WIDTH-bit adder built around one full-adder slice.
// Operands are captured on an accepted start and fed LSB first, one bit per clock,
// with a registered carry. The result and carry-out are published with a one-cycle
// done pulse and then held until the next completion or reset.
// Optional feature macro: SERIAL_ADDER_SUB_EN (adds a 'sub' port for a - b).
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    // Exit on the WIDTH-th run edge, so a power-of-two counter never wraps.
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_reg;
    logic [WIDTH-1:0]  sha_reg;
    logic [WIDTH-1:0]  shb_reg;
    logic [WIDTH-1:0]  res_reg;
    logic              carry_reg;
    logic [CW-1:0]     cnt_reg;

    logic [WIDTH-1:0]  b_load;
    logic              cin_load;
    logic              slice_s;
    logic              slice_c;
    logic [WIDTH-1:0]  res_next;

`ifdef SERIAL_ADDER_SUB_EN
    // Subtraction is a + ~b + 1: invert B on capture and preset the carry.
    assign b_load   = sub ? ~b : b;
    assign cin_load = sub;
`else
    // Add-only build: B captured as-is, carry starts clear.
    assign b_load   = b;
    assign cin_load = 1'b0;
`endif

    // The single full-adder slice working on the current LSBs.
    assign slice_s  = sha_reg[0] ^ shb_reg[0] ^ carry_reg;
    assign slice_c  = (sha_reg[0] & shb_reg[0]) |
                      (sha_reg[0] & carry_reg)  |
                      (shb_reg[0] & carry_reg);

    // Result enters at the MSB; after WIDTH shifts bit 0 sits at position 0.
    assign res_next = {slice_s, res_reg[WIDTH-1:1]};

    // Sequencer FSM with registered busy/done and held result outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            sha_reg   <= '0;
            shb_reg   <= '0;
            res_reg   <= '0;
            carry_reg <= 1'b0;
            cnt_reg   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    busy <= 1'b0;
                    done <= 1'b0;
                    if (start) begin
                        sha_reg   <= a;
                        shb_reg   <= b_load;
                        carry_reg <= cin_load;
                        cnt_reg   <= '0;
                        busy      <= 1'b1;
                        state_reg <= RUN;
                    end
                end
                RUN: begin
                    sha_reg   <= sha_reg >> 1;
                    shb_reg   <= shb_reg >> 1;
                    carry_reg <= slice_c;
                    res_reg   <= res_next;
                    cnt_reg   <= cnt_reg + CW'(1);
                    if (cnt_reg == LAST) begin
                        sum       <= res_next;
                        cout      <= slice_c;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state_reg <= DONE;
                    end
                end
                DONE: begin
                    done      <= 1'b0;
                    busy      <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    busy      <= 1'b0;
                    done      <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl (WIDTH=8) with an expected-result queue.
module tb_serial_adder_ctrl;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    int checks = 0;
    int errors = 0;
    logic [WIDTH:0] exp_q[$];

    serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
`ifdef SERIAL_ADDER_SUB_EN
        .sub   (sub),
`endif
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                             input logic s);
        logic [WIDTH:0] r;
        if (s) r = {1'b0, x} + {1'b0, ~y} + (WIDTH+1)'(1);
        else   r = {1'b0, x} + {1'b0, y};
        return r;
    endfunction

    // Pop the oldest expectation and compare it against the published result.
    task automatic check_result(input string tag);
        logic [WIDTH:0] e;
        if (exp_q.size() == 0) begin
            chk({tag, "_queue_empty"}, 64'd0, 64'd1);
        end else begin
            e = exp_q.pop_front();
            chk(tag, {55'd0, cout, sum}, {55'd0, e});
        end
    endtask

    // Advance negedge by negedge until done, counting busy cycles and watching result hold.
    task automatic wait_done(input logic [WIDTH:0] held, output bit seen, output int bc, output bit hold_ok);
        seen = 0; bc = 0; hold_ok = 1;
        for (int i = 0; i < 30; i++) begin
            if (done) begin
                seen = 1;
                break;
            end
            if (busy) bc++;
            if ({cout, sum} !== held) hold_ok = 0;
            @(negedge clk);
        end
    endtask

    task automatic run_op(input string tag, input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                          input logic ts);
        logic [WIDTH:0] held;
        bit seen, hold_ok;
        int bc;
        @(negedge clk);
        held = {cout, sum};
        a = ta; b = tb; sub = ts; start = 1'b1;
        exp_q.push_back(model(ta, tb, ts));
        @(negedge clk);
        start = 1'b0;
        a = WIDTH'($urandom); b = WIDTH'($urandom); sub = ~ts;
        wait_done(held, seen, bc, hold_ok);
        chk({tag, "_done_seen"}, 64'(seen), 64'd1);
        chk({tag, "_busy_cycles"}, 64'(bc), 64'(WIDTH));
        chk({tag, "_hold"}, 64'(hold_ok), 64'd1);
        chk({tag, "_busy_in_done"}, 64'(busy), 64'd0);
        check_result(tag);
        $display("op %s: a=0x%02h b=0x%02h sub=%0b -> sum=0x%02h cout=%0b", tag, ta, tb, ts, sum, cout);
        @(negedge clk);
        chk({tag, "_done_pulse"}, 64'(done), 64'd0);
    endtask

    initial begin
        bit seen, hold_ok, extra;
        int bc, n, last;
        logic [WIDTH:0] held;

        rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_sum",  64'(sum),  64'd0);
        chk("rst_cout", 64'(cout), 64'd0);
        $display("reset: busy=%0b done=%0b sum=0x%02h cout=%0b", busy, done, sum, cout);
        rst = 1'b0;

        run_op("add_5a_3c", 8'h5A, 8'h3C, 1'b0);
        chk("add_5a_3c_sum_const", 64'(sum), 64'h96);
        run_op("add_ff_01", 8'hFF, 8'h01, 1'b0);
        run_op("add_ff_ff", 8'hFF, 8'hFF, 1'b0);

        // Second start during RUN must be ignored.
        @(negedge clk);
        held = {cout, sum};
        a = 8'h01; b = 8'h02; start = 1'b1;
        exp_q.push_back(model(8'h01, 8'h02, 1'b0));
        @(negedge clk); start = 1'b0;
        @(negedge clk); a = 8'h7F; b = 8'h7F; start = 1'b1;
        @(negedge clk); start = 1'b0;
        wait_done(held, seen, bc, hold_ok);
        chk("ign_done_seen", 64'(seen), 64'd1);
        chk("ign_hold", 64'(hold_ok), 64'd1);
        check_result("ign_result");
        $display("op ign: a=0x01 b=0x02 (restart ignored) -> sum=0x%02h cout=%0b", sum, cout);
        extra = 0;
        repeat (12) begin
            @(negedge clk);
            if (done || busy) extra = 1;
        end
        chk("ign_single_done", 64'(extra), 64'd0);

        // Result 0x03 must hold during this run.
        run_op("hold_ff_ff", 8'hFF, 8'hFF, 1'b0);

        // Reset in the middle of a run.
        @(negedge clk);
        a = 8'hAA; b = 8'h55; start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_sum",  64'(sum),  64'd0);
        chk("abort_cout", 64'(cout), 64'd0);
        $display("abort: busy=%0b done=%0b sum=0x%02h cout=%0b", busy, done, sum, cout);
        @(negedge clk); rst = 1'b0;
        run_op("post_abort", 8'h10, 8'h20, 1'b0);

        // Start held high: done every WIDTH+2 cycles.
        @(negedge clk);
        a = 8'h11; b = 8'h22; sub = 1'b0; start = 1'b1;
        repeat (3) exp_q.push_back(model(8'h11, 8'h22, 1'b0));
        n = 0; last = 0;
        for (int c = 0; c < 60 && n < 3; c++) begin
            @(negedge clk);
            if (done) begin
                if (n > 0) chk("b2b_gap", 64'(c - last), 64'(WIDTH + 2));
                last = c;
                n++;
                check_result("b2b_result");
                $display("op b2b #%0d: a=0x11 b=0x22 -> sum=0x%02h cout=%0b", n, sum, cout);
                if (n == 3) start = 1'b0;
            end
        end
        start = 1'b0;
        chk("b2b_count", 64'(n), 64'd3);
        repeat (3) @(negedge clk);

`ifdef SERIAL_ADDER_SUB_EN
        run_op("sub_10_01", 8'h10, 8'h01, 1'b1);
        run_op("sub_00_01", 8'h00, 8'h01, 1'b1);
        run_op("add_10_01", 8'h10, 8'h01, 1'b0);
`endif

        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global timeout guard.
    initial begin
        #200000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
